// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port among NREQ
// write-back requesters. Each requester has a one-entry buffer, and one
// buffered write is granted per cycle onto registered write outputs.
// Writes to register 0 are accepted and then dropped.
// Ports: clk, rst (async, active-low); req_valid/req_addr/req_data in,
// req_ready out (valid/ready per requester); write_reg/write1/write_data
// out to reg_file; grant_id (source of current write); busy.
// Option: define RF_ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority with requester 0 highest.
module rf_write_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic             write_reg,
   output logic [AW-1:0]    write1,
   output logic [DW-1:0]    write_data,
   output logic [1:0]       grant_id,
   output logic             busy
);

   typedef enum logic {EMPTY, FULL} buf_st_e;

   buf_st_e       st_q   [NREQ];
   buf_st_e       st_d   [NREQ];
   logic [AW-1:0] addr_q [NREQ];
   logic [AW-1:0] addr_d [NREQ];
   logic [DW-1:0] data_q [NREQ];
   logic [DW-1:0] data_d [NREQ];

   logic          wr_q, wr_d;
   logic [AW-1:0] w1_q, w1_d;
   logic [DW-1:0] wd_q, wd_d;
   logic [1:0]    gid_q, gid_d;

   logic            any_gnt;
   logic [1:0]      gsel;
   logic [AW-1:0]   gaddr;
   logic [DW-1:0]   gdata;
   logic [NREQ-1:0] gnt;

`ifdef RF_ARB_RR_EN
   logic [1:0] ptr_q, ptr_d;

   function automatic int rr_idx(logic [1:0] p, int k);
      return (int'(p) + k) % NREQ;
   endfunction

   // Search begins just past the last granted requester.
   always_comb begin
      any_gnt = 1'b0;
      gsel    = '0;
      gaddr   = '0;
      gdata   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_gnt && st_q[rr_idx(ptr_q, k)] == FULL) begin
            any_gnt = 1'b1;
            gsel    = 2'(rr_idx(ptr_q, k));
            gaddr   = addr_q[rr_idx(ptr_q, k)];
            gdata   = data_q[rr_idx(ptr_q, k)];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (any_gnt) ptr_d = gsel;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= 2'(NREQ - 1);
      else      ptr_q <= ptr_d;
   end
`else
   always_comb begin
      any_gnt = 1'b0;
      gsel    = '0;
      gaddr   = '0;
      gdata   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_gnt && st_q[k] == FULL) begin
            any_gnt = 1'b1;
            gsel    = 2'(k);
            gaddr   = addr_q[k];
            gdata   = data_q[k];
         end
      end
   end
`endif

   // A granted buffer drains this edge, so it can take a new entry now.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         gnt[i]       = any_gnt && (gsel == 2'(i));
         req_ready[i] = (st_q[i] == EMPTY) || gnt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         st_d[i]   = st_q[i];
         addr_d[i] = addr_q[i];
         data_d[i] = data_q[i];
         if (req_valid[i] && req_ready[i]) begin
            if (req_addr[i*AW +: AW] != '0) begin
               st_d[i]   = FULL;
               addr_d[i] = req_addr[i*AW +: AW];
               data_d[i] = req_data[i*DW +: DW];
            end else begin
               st_d[i] = EMPTY;
            end
         end else if (gnt[i]) begin
            st_d[i] = EMPTY;
         end
      end
   end

   always_comb begin
      wr_d  = any_gnt;
      w1_d  = w1_q;
      wd_d  = wd_q;
      gid_d = gid_q;
      if (any_gnt) begin
         w1_d  = gaddr;
         wd_d  = gdata;
         gid_d = gsel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            st_q[i]   <= EMPTY;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_q  <= 1'b0;
         w1_q  <= '0;
         wd_q  <= '0;
         gid_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            st_q[i]   <= st_d[i];
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
         wr_q  <= wr_d;
         w1_q  <= w1_d;
         wd_q  <= wd_d;
         gid_q <= gid_d;
      end
   end

   always_comb begin
      busy = wr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (st_q[i] == FULL) busy = 1'b1;
      end
   end

   assign write_reg  = wr_q;
   assign write1     = w1_q;
   assign write_data = wd_q;
   assign grant_id   = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random stimulus for rf_write_arbiter,
// checked against a pending-write model of the arbitration rules.
module tb_rf_write_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*AW-1:0] req_addr  = '0;
   logic [NREQ*DW-1:0] req_data  = '0;
   logic [NREQ-1:0]    req_ready;
   logic             write_reg;
   logic [AW-1:0]    write1;
   logic [DW-1:0]    write_data;
   logic [1:0]       grant_id;
   logic             busy;

   int ncomp = 0;
   int nfail = 0;

   bit   m_full [NREQ];
   int   m_addr [NREQ];
   int   m_data [NREQ];
   int   m_ptr;
   bit   m_wr;
   int   m_w1, m_wd, m_gid;

   rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready),
      .write_reg(write_reg), .write1(write1), .write_data(write_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < NREQ; i++) begin
         m_full[i] = 0;
         m_addr[i] = 0;
         m_data[i] = 0;
      end
      m_ptr = NREQ - 1;
      m_wr  = 0;
      m_w1  = 0;
      m_wd  = 0;
      m_gid = 0;
   endtask

   function automatic int pick();
`ifdef RF_ARB_RR_EN
      for (int k = 1; k <= NREQ; k++) begin
         int j = (m_ptr + k) % NREQ;
         if (m_full[j]) return j;
      end
`else
      for (int j = 0; j < NREQ; j++)
         if (m_full[j]) return j;
`endif
      return -1;
   endfunction

   task automatic setreq(int i, logic v, logic [AW-1:0] ad, logic [DW-1:0] dt);
      req_valid[i]          = v;
      req_addr[i*AW +: AW]  = ad;
      req_data[i*DW +: DW]  = dt;
   endtask

   // One clock: check ready, advance model across the edge, check outputs.
   task automatic step();
      int g;
      logic [NREQ-1:0] rdy;
      bit busy_e;
      #1;
      g = pick();
      for (int i = 0; i < NREQ; i++)
         rdy[i] = !m_full[i] || (g == i);
      chk("ready", 32'(req_ready), 32'(rdy));
      @(posedge clk);
      if (g >= 0) begin
         m_wr  = 1;
         m_w1  = m_addr[g];
         m_wd  = m_data[g];
         m_gid = g;
         m_ptr = g;
      end else begin
         m_wr = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && rdy[i]) begin
            m_full[i] = (req_addr[i*AW +: AW] != 0);
            if (m_full[i]) begin
               m_addr[i] = int'(req_addr[i*AW +: AW]);
               m_data[i] = int'(req_data[i*DW +: DW]);
            end
         end else if (g == i) begin
            m_full[i] = 0;
         end
      end
      #1;
      busy_e = m_wr;
      for (int i = 0; i < NREQ; i++) busy_e |= m_full[i];
      chk("write_reg", 32'(write_reg), 32'(m_wr));
      chk("write1", 32'(write1), 32'(m_w1));
      chk("write_data", write_data, m_wd);
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("busy", 32'(busy), 32'(busy_e));
   endtask

   initial begin
      mreset();
      // Reset state
      #2;
      chk("rst_write_reg", 32'(write_reg), 0);
      chk("rst_write1", 32'(write1), 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 32'h7);
      #6 rst = 1'b1;
      @(posedge clk);
      #1;

      // Single write
      setreq(1, 1, 5, 3);
      step();
      setreq(1, 0, 0, 0);
      step();
      chk("single_wr", 32'(write_reg), 1);
      chk("single_w1", 32'(write1), 5);
      chk("single_wd", write_data, 3);
      chk("single_gid", 32'(grant_id), 1);
      step();
      chk("single_wr_off", 32'(write_reg), 0);

      // Zero-register drop
      setreq(0, 1, 0, 32'hFFFF_FFFF);
      step();
      setreq(0, 0, 0, 0);
      chk("zero_ready", 32'(req_ready[0]), 1);
      chk("zero_busy", 32'(busy), 0);
      step();
      chk("zero_wr", 32'(write_reg), 0);
      step();

      // Contention
      setreq(0, 1, 1, 32'h11);
      setreq(1, 1, 2, 32'h22);
      setreq(2, 1, 3, 32'h33);
      step();
      for (int c = 0; c < 6; c++) begin
         step();
`ifdef RF_ARB_RR_EN
         chk("rr_gid", 32'(grant_id), c % 3);
`else
         chk("fp_gid", 32'(grant_id), 0);
`endif
         chk("cont_w1", 32'(write1), 32'(grant_id) + 1);
      end
      req_valid = '0;
      for (int c = 0; c < 4; c++) step();
      chk("cont_idle", 32'(busy), 0);

      // Back-to-back single requester
      setreq(2, 1, 7, 32'h70);
      step();
      setreq(2, 1, 8, 32'h80);
      chk("b2b_ready", 32'(req_ready[2]), 1);
      step();
      chk("b2b_w1_7", 32'(write1), 7);
      setreq(2, 1, 9, 32'h90);
      chk("b2b_ready", 32'(req_ready[2]), 1);
      step();
      chk("b2b_w1_8", 32'(write1), 8);
      setreq(2, 0, 0, 0);
      step();
      chk("b2b_w1_9", 32'(write1), 9);
      chk("b2b_wr", 32'(write_reg), 1);
      step();

      // Reset mid-traffic
      for (int i = 0; i < NREQ; i++) setreq(i, 1, 5'(10 + i), 32'(i));
      step();
      req_valid = '0;
      #1 rst = 1'b0;
      #1;
      mreset();
      chk("mid_rst_wr", 32'(write_reg), 0);
      chk("mid_rst_w1", 32'(write1), 0);
      chk("mid_rst_wd", write_data, 0);
      chk("mid_rst_ready", 32'(req_ready), 32'h7);
      #2 rst = 1'b1;
      for (int c = 0; c < 3; c++) step();
      chk("mid_rst_nowr", 32'(write_reg), 0);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            setreq(i, ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
         end
         step();
      end
      req_valid = '0;
      for (int c = 0; c < 5; c++) step();
      chk("final_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port among `NREQ` write-back requesters (ALU result, load data, multiply/divide unit) in the MIPS datapath. Each requester gets a one-entry holding buffer with a valid/ready handshake; one buffered write is granted per cycle and driven onto registered `write_reg`/`write1`/`write_data` outputs that connect directly to `reg_file`. Writes to `$zero` are absorbed and never reach the register file.

## Interface
- `NREQ`, 3, number of requesters (supported 2..4)
- `DW`, 32, write data width
- `AW`, 5, register address width
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req_valid` in NREQ: per-requester write request
- `req_addr` in NREQ*AW: destination register, requester i at bits [i*AW +: AW]
- `req_data` in NREQ*DW: write data, requester i at bits [i*DW +: DW]
- `req_ready` out NREQ: per-requester accept; transfer when valid & ready at an edge
- `write_reg` out 1: register-file write enable
- `write1` out AW: register-file write address
- `write_data` out DW: register-file write data
- `grant_id` out 2: index of requester whose write is on the outputs
- `busy` out 1: any buffer full or `write_reg` high

## Operation
- Per-requester buffer, states EMPTY/FULL. EMPTY→FULL on accept with `req_addr` != 0; FULL→EMPTY on grant with no same-edge accept; FULL stays FULL on grant plus same-edge accept (new entry overwrites).
- Accept with `req_addr` == 0: handshake completes, buffer stays EMPTY, no write issued.
- `req_ready[i]` = buffer EMPTY or buffer i granted this cycle (combinational from arbitration; no dependence on `req_valid`).
- Arbitration: each cycle, exactly one FULL buffer is granted if any is FULL. Policy per Configuration.
- Grant registers buffer contents into `write1`/`write_data`, sets `write_reg`=1, `grant_id`=i. No grant: `write_reg`=0; `write1`, `write_data`, `grant_id` hold previous values.
- Ordering: writes from one requester leave in acceptance order. Across requesters, same-address writes leave in grant order; the later grant wins in the register file.
- Reset (rst low, any time): all buffers EMPTY, `write_reg`=0, `write1`=0, `write_data`=0, `grant_id`=0, round-robin pointer = NREQ-1, `busy`=0. In-flight entries discarded; `req_ready` all 1 once rst deasserts.

## Timing
- Accept at edge T → buffer FULL in cycle T..T+1 → if granted, outputs valid after edge T+1 → `reg_file` writes at edge T+2. Minimum latency 2 edges accept-to-register-file.
- Throughput: one write per cycle aggregate; a lone requester sustains one write per cycle (accept and grant on the same edge).
- Outputs are registers only; no combinational path from `req_*` to `write_*`.
- Starvation bound (round-robin): a FULL buffer is granted within NREQ cycles.
- `busy` is combinational from buffer state and `write_reg`.

## Configuration
- `RF_ARB_RR_EN` defined: round-robin. Search starts at pointer+1 mod NREQ; pointer updates to granted index on each grant, holds otherwise.
- `RF_ARB_RR_EN` undefined: fixed priority, requester 0 highest, NREQ-1 lowest; pointer logic absent. Lower-index requesters may starve higher indices.

## Test plan
- Reset mid-traffic: fill all buffers, pulse rst low for 3 ns between edges → `write_reg`=0, `write1`=0, `write_data`=0, `req_ready`=3'b111 immediately, no writes after release.
- Single write: requester 1 sends addr 5, data 3 at edge T → `write_reg`=1, `write1`=5, `write_data`=3, `grant_id`=1 after edge T+1; `write_reg`=0 after T+2.
- `$zero` drop: requester 0 sends addr 0, data 0xFFFF_FFFF → `req_ready[0]` stays 1, `write_reg` never asserts, `busy` stays 0.
- Contention, `RF_ARB_RR_EN` defined: all three hold valid with addrs 1,2,3 for 6 cycles → grant sequence 0,1,2,0,1,2; each `req_ready` high only on its grant cycle after the first.
- Contention, `RF_ARB_RR_EN` undefined: same stimulus → grant_id 0 every cycle; requesters 1,2 granted only after requester 0 drops valid.
- Back-to-back single requester: requester 2 streams addrs 7,8,9 on consecutive edges → `write1` 7,8,9 on three consecutive cycles, `req_ready[2]` never low.
